// File: rtl/serie_paralelo_rx_if.sv
// Serial-in / parallel-out bus of the byte-aligning receiver.
interface serie_paralelo_rx_if;
  logic       data_in;
  logic [7:0] data_out;
  logic       valid_out;
  logic       active;

  // Source of the serial stream and consumer of the recovered bytes
  modport master (
    output data_in,
    input  data_out,
    input  valid_out,
    input  active
  );

  // Receiver side
  modport slave (
    input  data_in,
    output data_out,
    output valid_out,
    output active
  );
endinterface

// File: rtl/serie_paralelo_rx.sv
// Serial-to-parallel receiver with comma-based byte alignment.
// Hunts for COM at any bit offset, confirms N_COM aligned COMs, then emits
// every non-COM byte on its boundary. Alignment is only lost through reset.
module serie_paralelo_rx #(
  parameter logic [7:0]  COM   = 8'hBC,
  parameter int unsigned N_COM = 4
) (
  input logic                clk_8f,
  input logic                reset,
  serie_paralelo_rx_if.slave bus
);

  localparam int unsigned CntW = $clog2(N_COM + 1);
  localparam logic [CntW-1:0] NCom = CntW'(N_COM);

  typedef enum logic [1:0] {
    StSearch,
    StAlign,
    StActive
  } state_e;

  state_e          state_q, state_d;
  logic [7:0]      shift_q, shift_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [CntW-1:0] com_cnt_q, com_cnt_d;
  logic [7:0]      data_q, data_d;
  logic            valid_q, valid_d;
  logic            active_q, active_d;

  logic [7:0] window;
  logic       boundary;
  logic       is_com;

  // Current byte window includes the bit being sampled on this edge
  always_comb begin
    window   = {shift_q[6:0], bus.data_in};
    boundary = (bit_cnt_q == 3'd7);
    is_com   = (window == COM);
  end

  // Next-state and output logic for the alignment FSM
  always_comb begin
    state_d   = state_q;
    shift_d   = window;
    bit_cnt_d = bit_cnt_q + 3'd1;
    com_cnt_d = com_cnt_q;
    data_d    = data_q;
    valid_d   = valid_q;

    unique case (state_q)
      StSearch: begin
        valid_d = 1'b0;
        if (is_com) begin
          // Restart the byte phase so the next boundary lands 8 bits later
          bit_cnt_d = 3'd0;
          com_cnt_d = CntW'(1);
          state_d   = (N_COM <= 1) ? StActive : StAlign;
        end
      end
      StAlign: begin
        valid_d = 1'b0;
        if (boundary) begin
          if (is_com) begin
            if (com_cnt_q + CntW'(1) >= NCom) begin
              com_cnt_d = NCom;
              state_d   = StActive;
            end else begin
              com_cnt_d = com_cnt_q + CntW'(1);
            end
          end else begin
            com_cnt_d = '0;
            state_d   = StSearch;
          end
        end
      end
      StActive: begin
        if (boundary) begin
          if (is_com) begin
            valid_d = 1'b0;
          end else begin
            data_d  = window;
            valid_d = 1'b1;
          end
        end
      end
      default: begin
        state_d   = StSearch;
        com_cnt_d = '0;
        valid_d   = 1'b0;
      end
    endcase

    active_d = (state_d == StActive);
  end

  // State and output registers, synchronous active-low reset
  always_ff @(posedge clk_8f) begin
    if (!reset) begin
      state_q   <= StSearch;
      shift_q   <= 8'h00;
      bit_cnt_q <= 3'd0;
      com_cnt_q <= '0;
      data_q    <= 8'h00;
      valid_q   <= 1'b0;
      active_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      com_cnt_q <= com_cnt_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      active_q  <= active_d;
    end
  end

  assign bus.data_out  = data_q;
  assign bus.valid_out = valid_q;
  assign bus.active    = active_q;

endmodule

// File: tb/tb_serie_paralelo_rx.sv
// Self-checking bench for serie_paralelo_rx: scenario tasks with a queue of
// expected {active, valid_out, data_out} words per transmitted byte.
module tb_serie_paralelo_rx;

  logic clk_8f;
  logic reset;
  int   checks;
  int   errors;

  logic [9:0] sb[$];

  serie_paralelo_rx_if bus_if ();

  serie_paralelo_rx #(
    .COM   (8'hBC),
    .N_COM (4)
  ) dut (
    .clk_8f (clk_8f),
    .reset  (reset),
    .bus    (bus_if)
  );

  initial clk_8f = 1'b0;
  always #5 clk_8f = ~clk_8f;

  function automatic logic [9:0] sample();
    return {bus_if.active, bus_if.valid_out, bus_if.data_out};
  endfunction

  // One bit: driven on the falling edge, sampled 1 time unit after the rise
  task automatic send_bit(input logic v);
    @(negedge clk_8f);
    bus_if.data_in = v;
    @(posedge clk_8f);
    #1;
  endtask

  // One byte MSB first; reports final outputs and whether they held over bits 7..1
  task automatic send_byte(input logic [7:0] b, output logic [9:0] obs, output bit held);
    logic [9:0] start;
    start = sample();
    held  = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      send_bit(b[i]);
      if (i > 0 && sample() !== start) held = 1'b0;
    end
    obs = sample();
  endtask

  task automatic apply_reset();
    @(negedge clk_8f);
    reset = 1'b0;
    bus_if.data_in = 1'b0;
    @(posedge clk_8f);
    @(negedge clk_8f);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    logic [9:0] got;
    reset = 1'b0;
    bus_if.data_in = 1'b1;
    repeat (3) @(posedge clk_8f);
    #1;
    got = sample();
    checks++;
    if (got !== 10'h000) begin
      errors++;
      $display("FAIL reset_state got %h want %h", got, 10'h000);
    end
    @(negedge clk_8f);
    reset = 1'b1;
    bus_if.data_in = 1'b0;
  endtask

  task automatic test_lock();
    logic [9:0] obs, exp;
    bit         held;
    logic [7:0] pay[4] = '{8'hFF, 8'hEE, 8'h4E, 8'h44};
    logic [7:0] b;
    apply_reset();
    for (int k = 0; k < 4; k++) begin
      sb.push_back({(k == 3), 1'b0, 8'h00});
      send_byte(8'hBC, obs, held);
      exp = sb.pop_front();
      checks++;
      if (obs !== exp || !held) begin
        errors++;
        $display("FAIL lock_bc%0d got %h want %h held=%0d", k, obs, exp, held);
      end
    end
    for (int k = 0; k < 4; k++) begin
      sb.push_back({2'b11, pay[k]});
      send_byte(pay[k], obs, held);
      exp = sb.pop_front();
      checks++;
      if (obs !== exp || !held) begin
        errors++;
        $display("FAIL lock_payload%0d got %h want %h held=%0d", k, obs, exp, held);
      end
    end
    // Back-to-back random payload while locked
    for (int k = 0; k < 12; k++) begin
      b = 8'($urandom_range(0, 255));
      if (b == 8'hBC) b = 8'h3C;
      sb.push_back({2'b11, b});
      send_byte(b, obs, held);
      exp = sb.pop_front();
      checks++;
      if (obs !== exp || !held) begin
        errors++;
        $display("FAIL back_to_back%0d got %h want %h held=%0d", k, obs, exp, held);
      end
    end
  endtask

  task automatic test_misaligned();
    logic [9:0] obs, exp;
    bit         held;
    apply_reset();
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    checks++;
    if (sample() !== 10'h000) begin
      errors++;
      $display("FAIL misaligned_junk got %h want %h", sample(), 10'h000);
    end
    for (int k = 0; k < 4; k++) begin
      sb.push_back({(k == 3), 1'b0, 8'h00});
      send_byte(8'hBC, obs, held);
      exp = sb.pop_front();
      checks++;
      if (obs !== exp || !held) begin
        errors++;
        $display("FAIL misaligned_bc%0d got %h want %h held=%0d", k, obs, exp, held);
      end
    end
    sb.push_back({2'b11, 8'hA5});
    send_byte(8'hA5, obs, held);
    exp = sb.pop_front();
    checks++;
    if (obs !== exp || !held) begin
      errors++;
      $display("FAIL misaligned_a5 got %h want %h held=%0d", obs, exp, held);
    end
  endtask

  task automatic test_broken_run();
    logic [9:0] obs, exp;
    bit         held;
    logic [7:0] seq[8] = '{8'hBC, 8'hBC, 8'h11, 8'hBC, 8'hBC, 8'hBC, 8'hBC, 8'h22};
    logic [9:0] want[8] = '{10'h000, 10'h000, 10'h000, 10'h000, 10'h000, 10'h000,
                            10'h200, 10'h322};
    apply_reset();
    for (int k = 0; k < 8; k++) begin
      sb.push_back(want[k]);
      send_byte(seq[k], obs, held);
      exp = sb.pop_front();
      checks++;
      if (obs !== exp || !held) begin
        errors++;
        $display("FAIL broken_run%0d got %h want %h held=%0d", k, obs, exp, held);
      end
    end
  endtask

  task automatic test_idle_in_active();
    logic [9:0] obs, exp;
    bit         held;
    logic [7:0] seq[8] = '{8'hBC, 8'hBC, 8'hBC, 8'hBC, 8'h33, 8'hBC, 8'hBC, 8'h55};
    logic [9:0] want[8] = '{10'h000, 10'h000, 10'h000, 10'h200, 10'h333, 10'h233,
                            10'h233, 10'h355};
    apply_reset();
    for (int k = 0; k < 8; k++) begin
      sb.push_back(want[k]);
      send_byte(seq[k], obs, held);
      exp = sb.pop_front();
      checks++;
      if (obs !== exp || !held) begin
        errors++;
        $display("FAIL idle_active%0d got %h want %h held=%0d", k, obs, exp, held);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [9:0] obs, exp;
    bit         held;
    logic [7:0] seq[5] = '{8'hBC, 8'hBC, 8'hBC, 8'hBC, 8'hA1};
    logic [9:0] want[5] = '{10'h000, 10'h000, 10'h000, 10'h200, 10'h3A1};
    apply_reset();
    for (int k = 0; k < 5; k++) begin
      sb.push_back(want[k]);
      send_byte(seq[k], obs, held);
      exp = sb.pop_front();
      checks++;
      if (obs !== exp || !held) begin
        errors++;
        $display("FAIL reset_mid_pre%0d got %h want %h held=%0d", k, obs, exp, held);
      end
    end
    // Upper nibble of 0x66, then a one-cycle reset, then the lower nibble
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    checks++;
    if (sample() !== 10'h3A1) begin
      errors++;
      $display("FAIL reset_mid_hold got %h want %h", sample(), 10'h3A1);
    end
    @(negedge clk_8f);
    reset = 1'b0;
    bus_if.data_in = 1'b1;
    @(posedge clk_8f);
    #1;
    checks++;
    if (sample() !== 10'h000) begin
      errors++;
      $display("FAIL reset_mid_clear got %h want %h", sample(), 10'h000);
    end
    @(negedge clk_8f);
    reset = 1'b1;
    bus_if.data_in = 1'b0;
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    checks++;
    if (sample() !== 10'h000) begin
      errors++;
      $display("FAIL reset_mid_no66 got %h want %h", sample(), 10'h000);
    end
    for (int k = 0; k < 4; k++) begin
      sb.push_back({(k == 3), 1'b0, 8'h00});
      send_byte(8'hBC, obs, held);
      exp = sb.pop_front();
      checks++;
      if (obs !== exp || !held) begin
        errors++;
        $display("FAIL reset_mid_relock%0d got %h want %h held=%0d", k, obs, exp, held);
      end
    end
    sb.push_back(10'h312);
    send_byte(8'h12, obs, held);
    exp = sb.pop_front();
    checks++;
    if (obs !== exp || !held) begin
      errors++;
      $display("FAIL reset_mid_post got %h want %h held=%0d", obs, exp, held);
    end
  endtask

  task automatic test_fewer_than_ncom();
    logic [9:0] obs, exp;
    bit         held;
    logic [7:0] seq[4] = '{8'hBC, 8'hBC, 8'hBC, 8'h77};
    apply_reset();
    for (int k = 0; k < 4; k++) begin
      sb.push_back(10'h000);
      send_byte(seq[k], obs, held);
      exp = sb.pop_front();
      checks++;
      if (obs !== exp || !held) begin
        errors++;
        $display("FAIL fewer_ncom%0d got %h want %h held=%0d", k, obs, exp, held);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b0;
    bus_if.data_in = 1'b0;
    test_reset();
    test_lock();
    test_misaligned();
    test_broken_run();
    test_idle_in_active();
    test_reset_mid();
    test_fewer_than_ncom();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serie_paralelo_rx.md
SERIE_PARALELO_RX -- requirements
Module: serie_paralelo_rx

Interface
REQ-001 The block SHALL have a parameter COM, default 8'hBC: the comma/idle symbol on the serial line.
REQ-002 The block SHALL have a parameter N_COM, default 4: the number of consecutive aligned COM bytes required to declare the link active.
REQ-003 The block SHALL have port clk_8f, input, 1 bit: the bit clock and the only clock; all logic SHALL act on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: reset, synchronous, active-low.
REQ-005 The block SHALL have port data_in, input, 1 bit: serial stream, MSB of each byte first.
REQ-006 The block SHALL have port data_out, output, 8 bits: the recovered parallel byte.
REQ-007 The block SHALL have port valid_out, output, 1 bit: data_out holds a non-COM payload byte.
REQ-008 The block SHALL have port active, output, 1 bit: byte alignment is achieved and N_COM COM bytes have been seen.

Function
REQ-009 The block SHALL shift data_in into an 8-bit shift register every cycle; window = {shift[6:0], data_in}.
REQ-010 The block SHALL keep a 3-bit bit counter that wraps 7->0 and marks the byte boundary at count 7.
REQ-011 The block SHALL implement FSM states SEARCH, ALIGN and ACTIVE.
REQ-012 In SEARCH, if window == COM in any cycle, the block SHALL set the bit counter to 0, set com_cnt to 1 and go to ALIGN; otherwise it SHALL stay in SEARCH, with the bit counter ignored.
REQ-013 In ALIGN, at each boundary: if window == COM, com_cnt SHALL increment; reaching N_COM SHALL go to ACTIVE.
REQ-014 In ALIGN, at a boundary with window != COM, com_cnt SHALL go to 0 and the FSM SHALL return to SEARCH, with no output change.
REQ-015 In ACTIVE, at each boundary with window != COM, data_out SHALL be loaded with the window and valid_out set to 1.
REQ-016 In ACTIVE, at a boundary with window == COM, valid_out SHALL be 0 and data_out SHALL hold its previous value.
REQ-017 data_out and valid_out SHALL change only at byte boundaries and hold for 8 cycles.
REQ-018 active SHALL be a registered output, 1 in ACTIVE and 0 otherwise, rising on the edge that samples the last bit of the N_COM-th COM.
REQ-019 Latency SHALL be 0 edges beyond the edge that samples bit 0 (LSB) of a byte: outputs are updated on that same edge.
REQ-020 ACTIVE SHALL be exited only by reset; in-band errors SHALL NOT drop alignment.
REQ-021 com_cnt SHALL saturate at N_COM and be sized for N_COM.
REQ-022 In SEARCH and ALIGN, valid_out SHALL be held at 0.

Reset
REQ-023 While reset == 0 at a rising edge, the block SHALL set shift = 0, bit counter = 0, com_cnt = 0, state = SEARCH, data_out = 8'h00, valid_out = 0 and active = 0.
REQ-024 Reset asserted mid-byte or in ACTIVE SHALL discard partial data; realignment SHALL require N_COM fresh COMs.
REQ-025 Reset deassertion SHALL take effect at the first edge with reset == 1; that edge's data_in bit SHALL be shifted normally.

Verification
REQ-026 Scenario, lock: reset, then 4 x BC, then FF, EE, 4E, 44 MSB-first -> active rises at the last bit of the 4th BC; data_out = FF, EE, 4E, 44 each for 8 cycles with valid_out = 1.
REQ-027 Scenario, misaligned start: 3 junk bits, then 4 x BC, then A5 -> lock found at the offset position; data_out = A5, valid_out = 1.
REQ-028 Scenario, broken run: BC, BC, 11, then 4 x BC, then 22 -> FSM returns to SEARCH after 11; active rises only after the later 4 BC; data_out = 22.
REQ-029 Scenario, idle in ACTIVE: active link, then 33, BC, BC, 55 -> valid_out = 1, 0, 0, 1; data_out = 33 held through the BCs, then 55.
REQ-030 Scenario, reset mid-operation: reset = 0 for 1 cycle in the middle of byte 66 while active -> all outputs = 0 next edge; 66 is never output; relock only after 4 new BC.
REQ-031 Scenario, fewer than N_COM: 3 x BC, then 77 -> active stays 0 and valid_out stays 0.
